// File: rtl/soc_arb_pkg.sv
// soc_arb_pkg: shared types and helpers for the memory-bus arbiter and its picker.
//   arb_state_t     arbiter FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   arb_idx_width   index width for n requesters, clog2(n) with a floor of 1
package soc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/soc_rr_picker.sv
// soc_rr_picker: combinational round-robin selector.
//   req    in   N    request vector
//   last   in   IW   index served most recently (lowest priority this round)
//   valid  out  1    at least one request is set
//   idx    out  IW   first set request scanning from last+1 upward, modulo N
module soc_rr_picker
    import soc_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = arb_idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(last) + k) % N;
            if (!valid && req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/soc_membus_arbiter.sv
// soc_membus_arbiter: round-robin arbiter sharing one memory-bus slave among
// N_MASTERS masters, one outstanding transaction at a time.
//   clk, resn                      clock (rising edge), asynchronous active-low reset
//   m_req/m_wr                     per-master request and direction (1 = write)
//   m_addr/m_wdata/m_wstrb         packed per-master fields, master i at [i*W +: W]
//   m_ready/m_err                  one-cycle completion / error pulse to the granted master
//   m_rdata                        shared read data, valid with m_ready, held until next completion
//   s_req/s_wr/s_addr/s_wdata/s_wstrb  latched request presented to the slave
//   s_ready/s_rdata                slave completion and read data
//   grant_id                       current or last granted master
//   busy                           high in BUSY and DONE
// Optional feature: define SOC_ARB_TIMEOUT_EN to abandon a slave access after
// TIMEOUT_CYCLES busy cycles, completing it with m_err and all-ones read data.
module soc_membus_arbiter
    import soc_arb_pkg::*;
#(
    parameter  int unsigned N_MASTERS      = 2,
    parameter  int unsigned ADDR_WIDTH     = 32,
    parameter  int unsigned DATA_WIDTH     = 32,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned SW             = DATA_WIDTH / 8,
    localparam int unsigned IW             = arb_idx_width(N_MASTERS)
) (
    input  logic                            clk,
    input  logic                            resn,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_wr,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [N_MASTERS*SW-1:0]         m_wstrb,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic [N_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic                            s_req,
    output logic                            s_wr,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    output logic [SW-1:0]                   s_wstrb,
    input  logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_rdata,
    output logic [IW-1:0]                   grant_id,
    output logic                            busy
);

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
        $error("N_MASTERS must be in 2..8");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t           state;
    logic [IW-1:0]        last_grant;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [N_MASTERS-1:0] grant_onehot;

    soc_rr_picker #(.N(N_MASTERS)) u_picker (
        .req   (m_req),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant_onehot = N_MASTERS'(1) << grant_id;

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0]        wait_cnt;
    logic [N_MASTERS-1:0] m_err_q;
    assign m_err = m_err_q;
`else
    assign m_err = '0;
`endif

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state      <= ARB_IDLE;
            last_grant <= IW'(N_MASTERS - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
            s_req      <= 1'b0;
            s_wr       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m_ready    <= '0;
            m_rdata    <= '0;
`ifdef SOC_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            m_err_q    <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        s_req    <= 1'b1;
                        s_wr     <= m_wr[pick_idx];
                        s_addr   <= m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        s_wdata  <= m_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        s_wstrb  <= m_wstrb[pick_idx*SW +: SW];
                        busy     <= 1'b1;
                        state    <= ARB_BUSY;
`ifdef SOC_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    // A completing slave beats a coincident timeout.
                    if (s_ready) begin
                        s_req      <= 1'b0;
                        m_rdata    <= s_rdata;
                        m_ready    <= grant_onehot;
                        last_grant <= grant_id;
                        state      <= ARB_DONE;
                    end
`ifdef SOC_ARB_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        s_req      <= 1'b0;
                        m_rdata    <= '1;
                        m_ready    <= grant_onehot;
                        m_err_q    <= grant_onehot;
                        last_grant <= grant_id;
                        state      <= ARB_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                ARB_DONE: begin
                    m_ready <= '0;
                    busy    <= 1'b0;
                    state   <= ARB_IDLE;
`ifdef SOC_ARB_TIMEOUT_EN
                    m_err_q <= '0;
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_membus_arbiter.sv
// tb_soc_membus_arbiter: self-checking bench for soc_membus_arbiter (2 masters,
// 32-bit address/data). Timeout scenarios are compiled in with SOC_ARB_TIMEOUT_EN.
module tb_soc_membus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          resn;
    logic [N-1:0]  m_req, m_wr, m_ready, m_err;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata, s_wdata, s_rdata;
    logic          s_req, s_wr, s_ready, busy;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_wstrb;
    logic [0:0]    grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_membus_arbiter #(
        .N_MASTERS      (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .resn     (resn),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_wr     (s_wr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: first requester after 'last', wrapping modulo N.
    function automatic int unsigned rr_pick(input logic [N-1:0] req, input int unsigned last);
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned j;
            j = (last + k) % N;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    task automatic set_master(input int unsigned i, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] st);
        m_wr[i]             = wr;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*SW +: SW] = st;
    endtask

    task automatic do_reset();
        resn    = 1'b0;
        m_req   = '0;
        m_wr    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_s_req",   64'(s_req),    64'd0);
        check("rst_m_ready", 64'(m_ready),  64'd0);
        check("rst_m_err",   64'(m_err),    64'd0);
        check("rst_busy",    64'(busy),     64'd0);
        check("rst_grant",   64'(grant_id), 64'd0);
        check("rst_m_rdata", 64'(m_rdata),  64'd0);
        check("rst_s_addr",  64'(s_addr),   64'd0);
        resn = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [31:0] addr0, addr1, wd0, wd1;
        logic [3:0]  st0, st1;
        int unsigned wait_c;
        logic [31:0] rdata;
        int unsigned exp_g;
    } vec_t;

    task automatic run_txn(input vec_t v);
        logic          ewr;
        logic [31:0]   ea, ed;
        logic [3:0]    es;
        ewr = v.wr[v.exp_g];
        ea  = (v.exp_g == 1) ? v.addr1 : v.addr0;
        ed  = (v.exp_g == 1) ? v.wd1   : v.wd0;
        es  = (v.exp_g == 1) ? v.st1   : v.st0;
        set_master(0, v.wr[0], v.addr0, v.wd0, v.st0);
        set_master(1, v.wr[1], v.addr1, v.wd1, v.st1);
        m_req   = v.req;
        s_ready = 1'b0;
        @(negedge clk);
        check("tbl_s_req",   64'(s_req),    64'd1);
        check("tbl_grant",   64'(grant_id), 64'(v.exp_g));
        check("tbl_s_wr",    64'(s_wr),     64'(ewr));
        check("tbl_s_addr",  64'(s_addr),   64'(ea));
        check("tbl_s_wdata", 64'(s_wdata),  64'(ed));
        check("tbl_s_wstrb", 64'(s_wstrb),  64'(es));
        check("tbl_busy",    64'(busy),     64'd1);
        for (int unsigned w = 0; w < v.wait_c; w++) begin
            @(negedge clk);
            check("tbl_wait_s_req",   64'(s_req),   64'd1);
            check("tbl_wait_m_ready", 64'(m_ready), 64'd0);
        end
        s_ready = 1'b1;
        s_rdata = v.rdata;
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = 32'h0;
        check("tbl_m_ready", 64'(m_ready), 64'(2'b01 << v.exp_g));
        check("tbl_m_rdata", 64'(m_rdata), 64'(v.rdata));
        check("tbl_m_err",   64'(m_err),   64'd0);
        check("tbl_done_s_req", 64'(s_req), 64'd0);
        m_req = '0;
        @(negedge clk);
        check("tbl_ready_drop", 64'(m_ready), 64'd0);
        check("tbl_busy_drop",  64'(busy),    64'd0);
        check("tbl_rdata_hold", 64'(m_rdata), 64'(v.rdata));
    endtask

    typedef enum {PH_FREE, PH_WAIT, PH_DONE} ph_t;

    initial begin
        vec_t        tbl [7];
        int          pulse_t [4];
        int unsigned pulse_g [4];
        int          npulse;

        tbl[0] = '{2'b01, 2'b00, 32'h100, 32'h200,  32'h11111111, 32'h22222222, 4'hF, 4'hF, 1, 32'h0000CAFE, 0};
        tbl[1] = '{2'b11, 2'b10, 32'h104, 32'h3000, 32'h00000000, 32'hDEADBEEF, 4'h1, 4'hC, 0, 32'h0BAD0001, 1};
        tbl[2] = '{2'b11, 2'b01, 32'h108, 32'h3004, 32'hA5A5A5A5, 32'h00000000, 4'h3, 4'hF, 2, 32'h55AA55AA, 0};
        tbl[3] = '{2'b10, 2'b00, 32'h10C, 32'h3008, 32'h0,        32'h0,        4'h0, 4'h0, 0, 32'h12340000, 1};
        tbl[4] = '{2'b10, 2'b10, 32'h110, 32'h300C, 32'h0,        32'h0F0F0F0F, 4'h0, 4'h8, 3, 32'hFFFF0000, 1};
        tbl[5] = '{2'b01, 2'b00, 32'h114, 32'h3010, 32'h0,        32'h0,        4'h0, 4'h0, 0, 32'h00000001, 0};
        tbl[6] = '{2'b11, 2'b11, 32'h118, 32'h3014, 32'h13579BDF, 32'h2468ACE0, 4'h6, 4'h9, 1, 32'h00000007, 1};

        do_reset();
        @(negedge clk);

        for (int unsigned r = 0; r < 7; r++) run_txn(tbl[r]);

        // Both masters requesting continuously against a zero-wait slave.
        npulse  = 0;
        m_req   = 2'b11;
        s_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_rdata = 32'hA0000000 + 32'(c);
            @(negedge clk);
            if (m_ready != 0) begin
                check("rot_rdata", 64'(m_rdata), 64'(32'hA0000000 + 32'(c)));
                if (npulse < 4) begin
                    pulse_t[npulse] = c;
                    pulse_g[npulse] = (m_ready == 2'b10) ? 1 : ((m_ready == 2'b01) ? 0 : 9);
                end
                npulse++;
            end
        end
        m_req   = '0;
        s_ready = 1'b0;
        check("rot_count", 64'(npulse), 64'd4);
        if (npulse >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rot_grant", 64'(pulse_g[k]), 64'(k % 2));
                if (k > 0) check("rot_spacing", 64'(pulse_t[k] - pulse_t[k-1]), 64'd3);
            end
        end
        repeat (2) @(negedge clk);

        // Master 1 write latched while both masters' fields move during BUSY.
        set_master(1, 1'b1, 32'h00002000, 32'h12345678, 4'b0011);
        set_master(0, 1'b0, 32'h00000500, 32'h0, 4'hF);
        m_req = 2'b10;
        @(negedge clk);
        check("hold_grant", 64'(grant_id), 64'd1);
        for (int c = 0; c < 4; c++) begin
            m_req = 2'b11;
            set_master(0, 1'b1, 32'h00000600 + 32'(c), 32'hFFFF0000, 4'hF);
            set_master(1, 1'b0, 32'h00009000 + 32'(c), 32'h0, 4'h0);
            @(negedge clk);
            check("hold_s_req",   64'(s_req),   64'd1);
            check("hold_s_wr",    64'(s_wr),    64'd1);
            check("hold_s_addr",  64'(s_addr),  64'h2000);
            check("hold_s_wdata", 64'(s_wdata), 64'h12345678);
            check("hold_s_wstrb", 64'(s_wstrb), 64'h3);
        end
        s_ready = 1'b1;
        s_rdata = 32'h0;
        @(negedge clk);
        s_ready = 1'b0;
        check("hold_m_ready", 64'(m_ready), 64'b10);
        m_req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("next_grant", 64'(grant_id), 64'd0);
        check("next_addr",  64'(s_addr),   64'h603);
        s_ready = 1'b1;
        s_rdata = 32'h0000BEEF;
        @(negedge clk);
        s_ready = 1'b0;
        m_req   = '0;
        check("next_m_ready", 64'(m_ready), 64'b01);
        @(negedge clk);

        // Reset in the middle of BUSY (last served is master 0 here).
        m_req = 2'b11;
        @(negedge clk);
        check("mid_grant", 64'(grant_id), 64'd1);
        #2 resn = 1'b0;
        #1;
        check("mid_rst_s_req", 64'(s_req),   64'd0);
        check("mid_rst_busy",  64'(busy),    64'd0);
        check("mid_rst_ready", 64'(m_ready), 64'd0);
        s_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_ready2", 64'(m_ready), 64'd0);
        s_ready = 1'b0;
        resn    = 1'b1;
        @(negedge clk);
        check("post_rst_s_req", 64'(s_req),    64'd1);
        check("post_rst_grant", 64'(grant_id), 64'd0);
        s_ready = 1'b1;
        s_rdata = 32'h00C0FFEE;
        @(negedge clk);
        s_ready = 1'b0;
        m_req   = '0;
        check("post_rst_ready", 64'(m_ready), 64'b01);
        @(negedge clk);

`ifdef SOC_ARB_TIMEOUT_EN
        begin
            int nbusy;
            bit seen;
            nbusy = 0;
            seen  = 1'b0;
            m_req = 2'b01;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (m_ready != 0) seen = 1'b1;
                else if (s_req) nbusy++;
            end
            check("to_seen",    64'(seen),    64'd1);
            check("to_cycles",  64'(nbusy),   64'(TO));
            check("to_m_ready", 64'(m_ready), 64'b01);
            check("to_m_err",   64'(m_err),   64'b01);
            check("to_m_rdata", 64'(m_rdata), 64'hFFFFFFFF);
            m_req = '0;
            @(negedge clk);
            check("to_err_drop", 64'(m_err), 64'd0);

            m_req = 2'b01;
            for (int c = 1; c <= int'(TO); c++) begin
                @(negedge clk);
                check("to_edge_s_req", 64'(s_req), 64'd1);
            end
            s_ready = 1'b1;
            s_rdata = 32'h5A5A1234;
            @(negedge clk);
            s_ready = 1'b0;
            m_req   = '0;
            check("to_edge_ready", 64'(m_ready), 64'b01);
            check("to_edge_err",   64'(m_err),   64'd0);
            check("to_edge_rdata", 64'(m_rdata), 64'h5A5A1234);
            @(negedge clk);
        end
`endif

        // Randomised traffic against a transaction-level reference.
        begin
            ph_t             mph;
            int unsigned     last_m, g_m, wcnt;
            logic [N-1:0]    p_req;
            logic [N-1:0]    p_wr;
            logic [N*AW-1:0] p_addr;
            logic [N*DW-1:0] p_wdata;
            logic [N*SW-1:0] p_wstrb;
            logic            p_sready;
            logic [DW-1:0]   p_srdata, exp_rd;
            logic            e_wr;
            logic [AW-1:0]   e_addr;
            logic [DW-1:0]   e_wdata;
            logic [SW-1:0]   e_wstrb;

            do_reset();
            mph = PH_FREE; last_m = N - 1; g_m = 0; wcnt = 0;
            exp_rd = '0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (mph == PH_DONE && g_m == i) m_req[i] = ($urandom_range(0, 1) == 1);
                    else if (!m_req[i])            m_req[i] = ($urandom_range(0, 2) == 0);
                    set_master(i, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom));
                end
                s_rdata = $urandom;
                if (mph == PH_WAIT) begin
                    if (wcnt == 0) s_ready = 1'b1;
                    else begin
                        s_ready = 1'b0;
                        wcnt--;
                    end
                end else begin
                    s_ready = ($urandom_range(0, 3) == 0);
                end
                p_req = m_req; p_wr = m_wr; p_addr = m_addr; p_wdata = m_wdata;
                p_wstrb = m_wstrb; p_sready = s_ready; p_srdata = s_rdata;

                @(negedge clk);
                check("rnd_m_err", 64'(m_err), 64'd0);
                case (mph)
                    PH_FREE: begin
                        if (p_req != 0) begin
                            g_m     = rr_pick(p_req, last_m);
                            e_wr    = p_wr[g_m];
                            e_addr  = p_addr[g_m*AW +: AW];
                            e_wdata = p_wdata[g_m*DW +: DW];
                            e_wstrb = p_wstrb[g_m*SW +: SW];
                            wcnt    = $urandom_range(0, 4);
                            mph     = PH_WAIT;
                            check("rnd_grant", 64'(grant_id), 64'(g_m));
                            check("rnd_s_req", 64'(s_req),    64'd1);
                        end else begin
                            check("rnd_idle_s_req", 64'(s_req), 64'd0);
                            check("rnd_idle_busy",  64'(busy),  64'd0);
                        end
                        check("rnd_free_ready", 64'(m_ready), 64'd0);
                    end
                    PH_WAIT: begin
                        if (p_sready) begin
                            check("rnd_m_ready", 64'(m_ready), 64'(2'b01 << g_m));
                            check("rnd_m_rdata", 64'(m_rdata), 64'(p_srdata));
                            check("rnd_done_s_req", 64'(s_req), 64'd0);
                            check("rnd_done_busy",  64'(busy),  64'd1);
                            exp_rd = p_srdata;
                            last_m = g_m;
                            mph    = PH_DONE;
                        end else begin
                            check("rnd_wait_s_req", 64'(s_req),   64'd1);
                            check("rnd_wait_ready", 64'(m_ready), 64'd0);
                        end
                    end
                    default: begin
                        check("rnd_after_ready", 64'(m_ready), 64'd0);
                        check("rnd_after_busy",  64'(busy),    64'd0);
                        check("rnd_rdata_hold",  64'(m_rdata), 64'(exp_rd));
                        mph = PH_FREE;
                    end
                endcase
                if (mph == PH_WAIT) begin
                    check("rnd_s_wr",    64'(s_wr),    64'(e_wr));
                    check("rnd_s_addr",  64'(s_addr),  64'(e_addr));
                    check("rnd_s_wdata", 64'(s_wdata), 64'(e_wdata));
                    check("rnd_s_wstrb", 64'(s_wstrb), 64'(e_wstrb));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
